// File: rtl/ram_responder.sv
// Word-addressed RAM endpoint that answers one arbitrated read/write request with a
// programmable number of BUSY wait cycles before a single ACCESS cycle.
//   state  | meaning
//   FREE   | no request, or reset held
//   BUSY   | request latched, counting down wait cycles
//   ACCESS | read data valid / write commits at the closing edge
//   ERROR  | both REN and WEN set, or address beyond DEPTH
module ram_responder #(
    parameter int unsigned LAT   = 2,
    parameter int unsigned DEPTH = 256
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        ram_ren_i,
    input  logic        ram_wen_i,
    input  logic [31:0] ram_addr_i,
    input  logic [31:0] ram_store_i,
    output logic [1:0]  ram_state_o,
    output logic [31:0] ram_load_o
);

    localparam int unsigned CW = (LAT < 1) ? 1 : $clog2(LAT + 1);
    localparam int unsigned AW = (DEPTH < 2) ? 1 : $clog2(DEPTH);
    localparam logic [CW-1:0] CNT_LOAD = CW'((LAT > 0) ? LAT - 1 : 0);

    typedef enum logic [1:0] {
        ST_FREE   = 2'd0,
        ST_BUSY   = 2'd1,
        ST_ACCESS = 2'd2,
        ST_ERROR  = 2'd3
    } ramstate_t;

    logic [31:0]   mem_q [DEPTH];
    logic          pend_q, pend_d;
    logic [1:0]    lop_q, lop_d;
    logic [AW-1:0] laddr_q, laddr_d;
    logic [CW-1:0] cnt_q, cnt_d;

    logic [29:0]   idx;
    logic [AW-1:0] widx;
    logic          idx_ok;
    logic          match;
    logic          mem_we;
    logic [1:0]    unused_addr;
    ramstate_t     state;

    assign idx         = ram_addr_i[31:2];
    assign widx        = idx[AW-1:0];
    assign idx_ok      = ({2'b00, idx} < 32'(DEPTH));
    assign unused_addr = ram_addr_i[1:0];

    // The full index is range-checked separately, so comparing the stored low bits suffices.
    assign match = pend_q && (lop_q == {ram_ren_i, ram_wen_i}) && (laddr_q == widx);

    always_comb begin
        state = ST_BUSY;
        if (!rst_ni) begin
            state = ST_FREE;
        end else if ((ram_ren_i && ram_wen_i) || ((ram_ren_i || ram_wen_i) && !idx_ok)) begin
            state = ST_ERROR;
        end else if (!ram_ren_i && !ram_wen_i) begin
            state = ST_FREE;
        end else if (LAT == 0) begin
            state = ST_ACCESS;
        end else if (match && (cnt_q == '0)) begin
            state = ST_ACCESS;
        end
    end

    always_comb begin
        pend_d  = pend_q;
        lop_d   = lop_q;
        laddr_d = laddr_q;
        cnt_d   = cnt_q;
        unique case (state)
            ST_FREE, ST_ERROR, ST_ACCESS: pend_d = 1'b0;
            ST_BUSY: begin
                if (match) begin
                    cnt_d = cnt_q - 1'b1;
                end else begin
                    pend_d  = 1'b1;
                    lop_d   = {ram_ren_i, ram_wen_i};
                    laddr_d = widx;
                    cnt_d   = CNT_LOAD;
                end
            end
            default: pend_d = 1'b0;
        endcase
    end

    assign mem_we      = (state == ST_ACCESS) && ram_wen_i;
    assign ram_state_o = state;
    assign ram_load_o  = ((state == ST_ACCESS) && ram_ren_i) ? mem_q[widx] : 32'h0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q  <= 1'b0;
            lop_q   <= 2'b00;
            laddr_q <= '0;
            cnt_q   <= '0;
        end else begin
            pend_q  <= pend_d;
            lop_q   <= lop_d;
            laddr_q <= laddr_d;
            cnt_q   <= cnt_d;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_q[i] <= 32'h0;
            end
        end else if (mem_we) begin
            mem_q[widx] <= ram_store_i;
        end
    end

endmodule

// File: tb/tb_ram_responder.sv
// Directed bench for ram_responder: a LAT=2 instance for handshake/latency/error cases
// and a LAT=0 instance for zero-wait back-to-back access.
module tb_ram_responder;

    localparam logic [1:0] FR = 2'd0;
    localparam logic [1:0] BS = 2'd1;
    localparam logic [1:0] AC = 2'd2;
    localparam logic [1:0] ER = 2'd3;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        ren, wen;
    logic [31:0] addr, store;
    logic [1:0]  state;
    logic [31:0] load;
    logic        ren0, wen0;
    logic [31:0] addr0, store0;
    logic [1:0]  state0;
    logic [31:0] load0;

    int n_cmp = 0;
    int n_mis = 0;

    always #5 clk = ~clk;

    ram_responder #(.LAT(2), .DEPTH(256)) u_dut (
        .clk_i(clk), .rst_ni(rst_n),
        .ram_ren_i(ren), .ram_wen_i(wen),
        .ram_addr_i(addr), .ram_store_i(store),
        .ram_state_o(state), .ram_load_o(load)
    );

    ram_responder #(.LAT(0), .DEPTH(256)) u_dut0 (
        .clk_i(clk), .rst_ni(rst_n),
        .ram_ren_i(ren0), .ram_wen_i(wen0),
        .ram_addr_i(addr0), .ram_store_i(store0),
        .ram_state_o(state0), .ram_load_o(load0)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_mis++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Apply inputs half a cycle before the edge, sample 1 ns later.
    task automatic step(input string tag, input logic r, input logic w,
                        input logic [31:0] a, input logic [31:0] d,
                        input logic [1:0] es, input logic [31:0] el);
        @(negedge clk);
        ren = r; wen = w; addr = a; store = d;
        #1;
        chk({tag, "_st"}, {30'b0, state}, {30'b0, es});
        chk({tag, "_ld"}, load, el);
    endtask

    task automatic step0(input string tag, input logic r, input logic w,
                         input logic [31:0] a, input logic [31:0] d,
                         input logic [1:0] es, input logic [31:0] el);
        @(negedge clk);
        ren0 = r; wen0 = w; addr0 = a; store0 = d;
        #1;
        chk({tag, "_st"}, {30'b0, state0}, {30'b0, es});
        chk({tag, "_ld"}, load0, el);
    endtask

    initial begin
        rst_n = 1'b0;
        ren = 1'b1; wen = 1'b0; addr = 32'h40; store = 32'h0;
        ren0 = 1'b0; wen0 = 1'b0; addr0 = 32'h0; store0 = 32'h0;
        @(negedge clk); @(negedge clk);
        #1;
        chk("rst_st", {30'b0, state}, {30'b0, FR});
        chk("rst_ld", load, 32'h0);
        chk("rst0_st", {30'b0, state0}, {30'b0, FR});
        @(negedge clk);
        ren = 1'b0;
        rst_n = 1'b1;
        #1;
        chk("idle_st", {30'b0, state}, {30'b0, FR});

        // write then read back
        step("wr40_0", 0, 1, 32'h40, 32'hDEADBEEF, BS, 32'h0);
        step("wr40_1", 0, 1, 32'h40, 32'hDEADBEEF, BS, 32'h0);
        step("wr40_2", 0, 1, 32'h40, 32'hDEADBEEF, AC, 32'h0);
        step("rd40_0", 1, 0, 32'h40, 32'h0, BS, 32'h0);
        step("rd40_1", 1, 0, 32'h40, 32'h0, BS, 32'h0);
        step("rd40_2", 1, 0, 32'h40, 32'h0, AC, 32'hDEADBEEF);
        // held read becomes a second transaction
        step("hold_3", 1, 0, 32'h40, 32'h0, BS, 32'h0);
        step("hold_4", 1, 0, 32'h40, 32'h0, BS, 32'h0);
        step("hold_5", 1, 0, 32'h40, 32'h0, AC, 32'hDEADBEEF);
        step("free_0", 0, 0, 32'h40, 32'h0, FR, 32'h0);

        // address change mid-wait restarts the count
        step("chg_0", 1, 0, 32'h40, 32'h0, BS, 32'h0);
        step("chg_1", 1, 0, 32'h44, 32'h0, BS, 32'h0);
        step("chg_2", 1, 0, 32'h44, 32'h0, BS, 32'h0);
        step("chg_3", 1, 0, 32'h44, 32'h0, AC, 32'h0);
        step("chk40_0", 1, 0, 32'h40, 32'h0, BS, 32'h0);
        step("chk40_1", 1, 0, 32'h40, 32'h0, BS, 32'h0);
        step("chk40_2", 1, 0, 32'h40, 32'h0, AC, 32'hDEADBEEF);

        // abandoned write leaves memory untouched
        step("abw_0", 0, 1, 32'h84, 32'h99, BS, 32'h0);
        step("abw_1", 1, 0, 32'h84, 32'h99, BS, 32'h0);
        step("abw_2", 1, 0, 32'h84, 32'h99, BS, 32'h0);
        step("abw_3", 1, 0, 32'h84, 32'h99, AC, 32'h0);

        // error cases
        step("both_0", 1, 1, 32'h0, 32'hFFFFFFFF, ER, 32'h0);
        step("both_1", 1, 1, 32'h0, 32'hFFFFFFFF, ER, 32'h0);
        step("both_2", 1, 1, 32'h0, 32'hFFFFFFFF, ER, 32'h0);
        step("oob_0", 0, 1, 32'h400, 32'hFFFFFFFF, ER, 32'h0);
        step("oob_1", 0, 1, 32'h400, 32'hFFFFFFFF, ER, 32'h0);
        step("oob_2", 0, 1, 32'h400, 32'hFFFFFFFF, ER, 32'h0);
        step("oobr_0", 1, 0, 32'h400, 32'h0, ER, 32'h0);
        step("rd0_0", 1, 0, 32'h0, 32'h0, BS, 32'h0);
        step("rd0_1", 1, 0, 32'h0, 32'h0, BS, 32'h0);
        step("rd0_2", 1, 0, 32'h0, 32'h0, AC, 32'h0);
        step("top_0", 0, 1, 32'h3FC, 32'h12345678, BS, 32'h0);
        step("top_1", 0, 1, 32'h3FC, 32'h12345678, BS, 32'h0);
        step("top_2", 0, 1, 32'h3FC, 32'h12345678, AC, 32'h0);
        step("rdtop_0", 1, 0, 32'h3FC, 32'h0, BS, 32'h0);
        step("rdtop_1", 1, 0, 32'h3FC, 32'h0, BS, 32'h0);
        step("rdtop_2", 1, 0, 32'h3FC, 32'h0, AC, 32'h12345678);

        // reset mid-wait aborts, held write restarts after release
        step("rmw_0", 0, 1, 32'h80, 32'h1, BS, 32'h0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("rmw_rst_st", {30'b0, state}, {30'b0, FR});
        chk("rmw_rst_ld", load, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rmw_r0_st", {30'b0, state}, {30'b0, BS});
        step("rmw_r1", 0, 1, 32'h80, 32'h1, BS, 32'h0);
        step("rmw_r2", 0, 1, 32'h80, 32'h1, AC, 32'h0);
        step("rd80_0", 1, 0, 32'h80, 32'h0, BS, 32'h0);
        step("rd80_1", 1, 0, 32'h80, 32'h0, BS, 32'h0);
        step("rd80_2", 1, 0, 32'h80, 32'h0, AC, 32'h1);
        step("rst40_0", 1, 0, 32'h40, 32'h0, BS, 32'h0);
        step("rst40_1", 1, 0, 32'h40, 32'h0, BS, 32'h0);
        step("rst40_2", 1, 0, 32'h40, 32'h0, AC, 32'h0);
        step("free_1", 0, 0, 32'h0, 32'h0, FR, 32'h0);

        // zero-wait instance
        step0("z_w0", 0, 1, 32'h8, 32'hA5A5A5A5, AC, 32'h0);
        step0("z_r0", 1, 0, 32'h8, 32'h0, AC, 32'hA5A5A5A5);
        step0("z_w1", 0, 1, 32'h8, 32'h5A5A5A5A, AC, 32'h0);
        step0("z_r1", 1, 0, 32'h8, 32'h0, AC, 32'h5A5A5A5A);
        step0("z_err", 1, 1, 32'h8, 32'hFFFFFFFF, ER, 32'h0);
        step0("z_r2", 1, 0, 32'h8, 32'h0, AC, 32'h5A5A5A5A);
        step0("z_free", 0, 0, 32'h8, 32'h0, FR, 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
